mcu_tx_scheduler: RTL and testbench

Packet-level scheduler that shares the single MCU-side `com_uart` transmitter between two byte streams: configuration/command responses (`cfg`) and received wireless payload (`wl`, drained from the FIFO512 path). It owns the `TX_flag_mcu` / `data_to_uart_mcu` drive into `com_uart`, paces bytes on the UART busy signal `TX_use_mcu`, and drives `AUX`. The arbitration is round-robin at packet boundaries, and a granted packet is never interleaved with the other stream.

---
 rtl/mcu_tx_scheduler.sv | 176 +++++++++++++++++
 tb/tb_mcu_tx_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_tx_scheduler.sv
// Packet-level round-robin scheduler sharing the MCU-side com_uart transmitter
// between the cfg and wl byte streams. Optional post-packet gap: MCU_TX_GAP_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no packet owned; arbitrate cfg/wl, capture first byte
// LOAD      | one-cycle TX_flag_mcu pulse for the captured byte
// WAIT_ACK  | wait for TX_use_mcu to rise, bounded by ACK_TIMEOUT
// WAIT_DONE | wait for TX_use_mcu to fall
// NEXT      | packet locked to grant; wait for the granted stream's next byte
// GAP       | idle spacing after a packet (MCU_TX_GAP_EN only)
module mcu_tx_scheduler #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned ACK_TIMEOUT = 16,
   parameter int unsigned GAP_CYCLES  = 32
) (
   input  logic                  internal_clk,
   input  logic                  rst_n,
   input  logic                  cfg_valid,
   input  logic [DATA_WIDTH-1:0] cfg_data,
   input  logic                  cfg_last,
   output logic                  cfg_ready,
   input  logic                  wl_valid,
   input  logic [DATA_WIDTH-1:0] wl_data,
   input  logic                  wl_last,
   output logic                  wl_ready,
   input  logic                  TX_use_mcu,
   output logic                  TX_flag_mcu,
   output logic [DATA_WIDTH-1:0] data_to_uart_mcu,
   output logic                  grant,
   output logic                  tx_err,
   output logic                  AUX
);

   localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

`ifdef MCU_TX_GAP_EN
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WAIT_ACK, S_WAIT_DONE, S_NEXT, S_GAP
   } state_t;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WAIT_ACK, S_WAIT_DONE, S_NEXT
   } state_t;
`endif

   state_t                state_q, state_d;
   logic                  grant_q, grant_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  last_q, last_d;
   logic                  prio_q, prio_d;
   logic                  aux_q, aux_d;
   logic [ACK_W-1:0]      ack_cnt_q, ack_cnt_d;
   logic                  cfg_take, wl_take, byte_done;

   always_ff @(posedge internal_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         grant_q   <= 1'b0;
         data_q    <= '0;
         last_q    <= 1'b0;
         prio_q    <= 1'b0;
         aux_q     <= 1'b0;
         ack_cnt_q <= '0;
`ifdef MCU_TX_GAP_EN
         gap_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         data_q    <= data_d;
         last_q    <= last_d;
         prio_q    <= prio_d;
         aux_q     <= aux_d;
         ack_cnt_q <= ack_cnt_d;
`ifdef MCU_TX_GAP_EN
         gap_cnt_q <= gap_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      data_d    = data_q;
      last_d    = last_q;
      prio_d    = prio_q;
      ack_cnt_d = ack_cnt_q;
      cfg_take  = 1'b0;
      wl_take   = 1'b0;
      byte_done = 1'b0;
      tx_err    = 1'b0;
`ifdef MCU_TX_GAP_EN
      gap_cnt_d = gap_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cfg_valid && (!wl_valid || !prio_q)) begin
               cfg_take = 1'b1;
               grant_d  = 1'b0;
               data_d   = cfg_data;
               last_d   = cfg_last;
               state_d  = S_LOAD;
            end else if (wl_valid) begin
               wl_take = 1'b1;
               grant_d = 1'b1;
               data_d  = wl_data;
               last_d  = wl_last;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            ack_cnt_d = '0;
            state_d   = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (TX_use_mcu) begin
               state_d = S_WAIT_DONE;
            end else if (ack_cnt_q == ACK_LAST) begin
               // UART never acknowledged: flag it and move on as if the byte finished
               tx_err    = 1'b1;
               byte_done = 1'b1;
            end else begin
               ack_cnt_d = ack_cnt_q + ACK_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!TX_use_mcu) byte_done = 1'b1;
         end
         S_NEXT: begin
            if (grant_q ? wl_valid : cfg_valid) begin
               cfg_take = !grant_q;
               wl_take  = grant_q;
               data_d   = grant_q ? wl_data : cfg_data;
               last_d   = grant_q ? wl_last : cfg_last;
               state_d  = S_LOAD;
            end
         end
`ifdef MCU_TX_GAP_EN
         S_GAP: begin
            if (gap_cnt_q == '0) state_d = S_IDLE;
            else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
         end
`endif
         default: state_d = S_IDLE;
      endcase

      if (byte_done) begin
         if (!last_q) begin
            state_d = S_NEXT;
         end else begin
            prio_d = ~grant_q;
`ifdef MCU_TX_GAP_EN
            gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
            state_d   = S_GAP;
`else
            state_d = S_IDLE;
`endif
         end
      end

      aux_d = (state_d == S_IDLE) && !cfg_valid && !wl_valid;
   end

   // Readies are combinational from state; gate them so reset holds both low
   assign cfg_ready        = cfg_take & rst_n;
   assign wl_ready         = wl_take & rst_n;
   assign TX_flag_mcu      = (state_q == S_LOAD);
   assign data_to_uart_mcu = data_q;
   assign grant            = grant_q;
   assign AUX              = aux_q;

endmodule

// File: tb/tb_mcu_tx_scheduler.sv
// Directed bench for mcu_tx_scheduler: vector table of packet scenarios plus
// hand sequences for ACK timeout, packet lock, reset mid-packet and (MCU_TX_GAP_EN) gap.
module tb_mcu_tx_scheduler;

   localparam int BUSY = 10;
   localparam int ACK_TO = 16;
   localparam int GAP = 32;

   typedef logic [7:0] b3_t [0:2];
   typedef logic [7:0] b6_t [0:5];
   typedef struct {
      bit        uc;
      b3_t       cb;
      int        nc;
      bit        uw;
      b3_t       wb;
      int        nw;
      b6_t       eb;
      logic [5:0] eg;
      int        ne;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_valid = 1'b0, cfg_last = 1'b0, wl_valid = 1'b0, wl_last = 1'b0;
   logic [7:0] cfg_data = '0, wl_data = '0;
   logic       cfg_ready, wl_ready, TX_flag_mcu, grant, tx_err, AUX;
   logic [7:0] data_to_uart_mcu;
   logic       TX_use_mcu = 1'b0;

   mcu_tx_scheduler dut (
      .internal_clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_last(cfg_last), .cfg_ready(cfg_ready),
      .wl_valid(wl_valid), .wl_data(wl_data), .wl_last(wl_last), .wl_ready(wl_ready),
      .TX_use_mcu(TX_use_mcu), .TX_flag_mcu(TX_flag_mcu), .data_to_uart_mcu(data_to_uart_mcu),
      .grant(grant), .tx_err(tx_err), .AUX(AUX)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_fail = 0;
   bit uart_silent = 1'b0;
   bit abort = 1'b0;
   bit drv_done = 1'b0;
   bit lock_watch = 1'b0;
   bit lock_early = 1'b0;
   bit gap_watch = 1'b0;
   bit gap_aux_hi = 1'b0;

   logic [7:0]  log_data[$];
   logic        log_grant[$];
   int unsigned flag_cyc[$];
   int unsigned err_cyc[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic clear_log();
      log_data.delete();
      log_grant.delete();
      flag_cyc.delete();
      err_cyc.delete();
   endtask

   // Bench UART: logs each start pulse and answers with BUSY cycles of TX_use_mcu
   always @(negedge clk) begin
      if (rst_n) begin
         if (TX_flag_mcu) begin
            log_data.push_back(data_to_uart_mcu);
            log_grant.push_back(grant);
            flag_cyc.push_back(cyc);
         end
         if (tx_err) err_cyc.push_back(cyc);
         if ((cfg_ready && !cfg_valid) || (wl_ready && !wl_valid) || (cfg_ready && wl_ready)) begin
            n_fail++;
            $display("FAIL ready_rule: cfg_ready=%0b wl_ready=%0b cfg_valid=%0b wl_valid=%0b",
                     cfg_ready, wl_ready, cfg_valid, wl_valid);
         end
         if (AUX && (TX_flag_mcu || TX_use_mcu)) begin
            n_fail++;
            $display("FAIL aux_busy: AUX=1 required 0 at cycle %0d", cyc);
         end
         if (lock_watch && cfg_ready && log_data.size() < 3) lock_early = 1'b1;
         if (gap_watch && AUX) gap_aux_hi = 1'b1;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && TX_flag_mcu && !uart_silent) begin
            @(posedge clk);
            #1 TX_use_mcu = 1'b1;
            repeat (BUSY) @(posedge clk);
            #1 TX_use_mcu = 1'b0;
         end
      end
   end

   function automatic bit rdy(input bit s);
      return s ? wl_ready : cfg_ready;
   endfunction

   task automatic drive(input bit s, input logic v, input logic [7:0] d, input logic l);
      if (s) begin wl_valid = v; wl_data = d; wl_last = l; end
      else   begin cfg_valid = v; cfg_data = d; cfg_last = l; end
   endtask

   task automatic send(input bit s, input b3_t b, input int n);
      int t;
      bit got;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         drive(s, 1'b1, b[i], (i == n - 1));
         t = 0;
         got = 1'b0;
         while (!got && t < 2000 && !abort) begin
            #1;
            if (rdy(s)) got = 1'b1;
            else begin @(negedge clk); t++; end
         end
         if (!got) begin
            if (!abort) begin
               n_fail++;
               $display("FAIL send_timeout: stream %0d byte %0d never accepted", s, i);
            end
            break;
         end
         @(posedge clk);
      end
      @(negedge clk);
      drive(s, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic wait_idle(input string nm);
      int t = 0;
      while (!AUX && t < 1000) begin @(negedge clk); t++; end
      chk(nm, AUX, 1);
   endtask

   task automatic wait_log(input string nm, input int n);
      int t = 0;
      while (log_data.size() < n && t < 1000) begin @(negedge clk); t++; end
      chk(nm, (log_data.size() >= n), 1);
   endtask

   task automatic chk_log(input string nm, input b6_t eb, input logic [5:0] eg, input int ne);
      chk({nm, "_count"}, log_data.size(), ne);
      for (int k = 0; k < ne; k++) begin
         if (k < log_data.size()) begin
            chk($sformatf("%s_byte%0d", nm, k), log_data[k], eb[k]);
            chk($sformatf("%s_grant%0d", nm, k), log_grant[k], eg[k]);
         end
      end
   endtask

   function automatic vec_t mk(input bit uc, input b3_t cb, input int nc, input bit uw,
                               input b3_t wb, input int nw, input b6_t eb,
                               input logic [5:0] eg, input int ne);
      vec_t v;
      v.uc = uc; v.cb = cb; v.nc = nc;
      v.uw = uw; v.wb = wb; v.nw = nw;
      v.eb = eb; v.eg = eg; v.ne = ne;
      return v;
   endfunction

   vec_t vecs[5];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // eg bit k is the expected grant of the k-th transmitted byte
      vecs[0] = mk(1, '{8'hAA, 8'hBB, 8'h00}, 2, 1, '{8'h11, 8'h22, 8'h00}, 2,
                   '{8'hAA, 8'hBB, 8'h11, 8'h22, 8'h00, 8'h00}, 6'b001100, 4);
      vecs[1] = mk(1, '{8'hC1, 8'h00, 8'h03}, 3, 0, '{8'h00, 8'h00, 8'h00}, 0,
                   '{8'hC1, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00}, 6'b000000, 3);
      vecs[2] = mk(1, '{8'hAA, 8'hBB, 8'h00}, 2, 1, '{8'h11, 8'h22, 8'h00}, 2,
                   '{8'h11, 8'h22, 8'hAA, 8'hBB, 8'h00, 8'h00}, 6'b000011, 4);
      vecs[3] = mk(0, '{8'h00, 8'h00, 8'h00}, 0, 1, '{8'h5A, 8'h6B, 8'h00}, 2,
                   '{8'h5A, 8'h6B, 8'h00, 8'h00, 8'h00, 8'h00}, 6'b000011, 2);
      vecs[4] = mk(1, '{8'h01, 8'h00, 8'h00}, 1, 1, '{8'h02, 8'h03, 8'h00}, 2,
                   '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00}, 6'b000110, 3);

      // reset state, with both valids high to prove readies are held low
      cfg_valid = 1'b1; wl_valid = 1'b1;
      #12;
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_wl_ready", wl_ready, 0);
      chk("rst_flag", TX_flag_mcu, 0);
      chk("rst_data", data_to_uart_mcu, 0);
      chk("rst_grant", grant, 0);
      chk("rst_err", tx_err, 0);
      chk("rst_aux", AUX, 0);
      cfg_valid = 1'b0; wl_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("aux_after_release", AUX, 1);

      for (int v = 0; v < 5; v++) begin
         clear_log();
         fork
            begin if (vecs[v].uc) send(1'b0, vecs[v].cb, vecs[v].nc); end
            begin if (vecs[v].uw) send(1'b1, vecs[v].wb, vecs[v].nw); end
         join
         wait_idle($sformatf("vec%0d_idle", v));
         chk_log($sformatf("vec%0d", v), vecs[v].eb, vecs[v].eg, vecs[v].ne);
         chk($sformatf("vec%0d_no_err", v), err_cyc.size(), 0);
      end

      // ACK timeout: UART never answers; both bytes still go out
      clear_log();
      uart_silent = 1'b1;
      send(1'b0, '{8'h77, 8'h78, 8'h00}, 2);
      wait_idle("to_idle");
      chk_log("to", '{8'h77, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00}, 6'b000000, 2);
      chk("to_err_count", err_cyc.size(), 2);
      if (err_cyc.size() == 2 && flag_cyc.size() == 2) begin
         chk("to_err_delay0", err_cyc[0] - flag_cyc[0], ACK_TO);
         chk("to_err_delay1", err_cyc[1] - flag_cyc[1], ACK_TO);
      end
      uart_silent = 1'b0;

      // packet lock: cfg shows up after the first wl byte and must wait
      clear_log();
      lock_early = 1'b0;
      lock_watch = 1'b1;
      fork
         send(1'b1, '{8'hFF, 8'h11, 8'h22}, 3);
         begin
            wait_log("lock_first_flag", 1);
            send(1'b0, '{8'h33, 8'h00, 8'h00}, 1);
         end
      join
      wait_idle("lock_idle");
      lock_watch = 1'b0;
      chk_log("lock", '{8'hFF, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00}, 6'b000111, 4);
      chk("lock_no_early_ready", lock_early, 0);

      // reset during WAIT_DONE of byte 2 of a wl packet
      clear_log();
      abort = 1'b0;
      drv_done = 1'b0;
      fork
         begin send(1'b1, '{8'h10, 8'h20, 8'h30}, 3); drv_done = 1'b1; end
      join_none
      wait_log("rstmid_byte2", 2);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_flag", TX_flag_mcu, 0);
      chk("rstmid_data", data_to_uart_mcu, 0);
      chk("rstmid_grant", grant, 0);
      chk("rstmid_err", tx_err, 0);
      chk("rstmid_aux", AUX, 0);
      chk("rstmid_wl_valid_held", wl_valid, 1);
      chk("rstmid_wl_ready", wl_ready, 0);
      abort = 1'b1;
      repeat (BUSY + 5) @(posedge clk);
      begin
         int t = 0;
         while (!drv_done && t < 100) begin @(negedge clk); t++; end
         chk("rstmid_driver_done", drv_done, 1);
      end
      abort = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rstmid_aux_release", AUX, 1);
      chk("rstmid_no_err", err_cyc.size(), 0);
      // prio was 1 before reset; after reset cfg must win the tie
      clear_log();
      fork
         send(1'b0, '{8'h55, 8'h00, 8'h00}, 1);
         send(1'b1, '{8'h66, 8'h00, 8'h00}, 1);
      join
      wait_idle("post_rst_idle");
      chk_log("post_rst", '{8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00}, 6'b000010, 2);

`ifdef MCU_TX_GAP_EN
      clear_log();
      gap_aux_hi = 1'b0;
      gap_watch = 1'b1;
      send(1'b1, '{8'hA1, 8'h00, 8'h00}, 1);
      send(1'b1, '{8'hA2, 8'h00, 8'h00}, 1);
      wait_log("gap_second_flag", 2);
      gap_watch = 1'b0;
      wait_idle("gap_idle");
      chk_log("gap", '{8'hA1, 8'hA2, 8'h00, 8'h00, 8'h00, 8'h00}, 6'b000011, 2);
      if (flag_cyc.size() == 2)
         chk("gap_spacing_ge", (flag_cyc[1] - flag_cyc[0]) >= GAP, 1);
      chk("gap_aux_low", gap_aux_hi, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
